// File: rtl/andor_rr_if.sv
// Request/result bundle between requesters, the round-robin arbiter and the result consumer.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface andor_rr_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2,
   parameter int unsigned CNTW = 16
);
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] opnd;
   logic [NREQ-1:0]   gnt;
   logic              res_valid;
   logic              res_y;
   logic [IDW-1:0]    res_id;
   logic              res_ready;
   logic              busy;
   logic [CNTW-1:0]   op_count;

   modport master (
      output req, opnd, res_ready,
      input  gnt, res_valid, res_y, res_id, busy, op_count
   );

   modport slave (
      input  req, opnd, res_ready,
      output gnt, res_valid, res_y, res_id, busy, op_count
   );
endinterface

// File: rtl/andor_rr_arbiter.sv
// Round-robin scheduler sharing one a&b | c&d evaluator among NREQ requesters.
// Define ANDOR_OPCNT_EN to build the saturating completed-operation counter on op_count.
module andor_rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2,
   parameter int unsigned CNTW = 16
) (
   input logic       clk,
   input logic       rst,
   andor_rr_if.slave arb_io
);

   typedef enum logic [1:0] {StIdle, StEval, StHold} state_e;

   state_e            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [3:0]        nib_q, nib_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              res_valid_q, res_valid_d;
   logic              res_y_q, res_y_d;
   logic [IDW-1:0]    res_id_q, res_id_d;
   logic              found;
   int unsigned       scan_idx;
   int unsigned       cand;
   logic              handshake;

   assign handshake = res_valid_q & arb_io.res_ready;

   // First asserted request at or after the rotating pointer, wrapping.
   always_comb begin
      found    = 1'b0;
      scan_idx = 0;
      cand     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr_q) + k) % NREQ;
         if (!found && |(arb_io.req & (NREQ'(1) << cand))) begin
            found    = 1'b1;
            scan_idx = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      nib_d       = nib_q;
      gnt_d       = '0;
      res_valid_d = res_valid_q;
      res_y_d     = res_y_q;
      res_id_d    = res_id_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_d   = NREQ'(1) << scan_idx;
               nib_d   = 4'(arb_io.opnd >> (4 * scan_idx));
               id_d    = IDW'(scan_idx);
               state_d = StEval;
            end
         end
         StEval: begin
            res_y_d     = (nib_q[3] & nib_q[2]) | (nib_q[1] & nib_q[0]);
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = StHold;
         end
         StHold: begin
            if (handshake) begin
               res_valid_d = 1'b0;
               ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         id_q        <= '0;
         nib_q       <= '0;
         gnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_y_q     <= 1'b0;
         res_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         nib_q       <= nib_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         res_y_q     <= res_y_d;
         res_id_q    <= res_id_d;
      end
   end

   assign arb_io.gnt       = gnt_q;
   assign arb_io.res_valid = res_valid_q;
   assign arb_io.res_y     = res_y_q;
   assign arb_io.res_id    = res_id_q;
   assign arb_io.busy      = (state_q != StIdle);

`ifdef ANDOR_OPCNT_EN
   logic [CNTW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (handshake && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign arb_io.op_count = cnt_q;
`else
   assign arb_io.op_count = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_andor_rr_arbiter.sv
// Self-checking bench for andor_rr_arbiter: directed cases plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_andor_rr_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
`ifdef ANDOR_OPCNT_EN
   localparam int unsigned CNTW = 2;
`else
   localparam int unsigned CNTW = 16;
`endif

   logic clk;
   logic rst;

   andor_rr_if #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

   andor_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int m_ptr;
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int winner(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic eval_nib(input logic [3:0] n);
      return (n[3] & n[2]) | (n[1] & n[0]);
   endfunction

   // One full grant/evaluate/hold/accept transaction, hold = cycles with res_ready low.
   task automatic do_op(input logic [NREQ-1:0] r, input logic [4*NREQ-1:0] o, input int hold);
      int w;
      logic [3:0] nib;
      logic exp_y;
      w   = winner(r, m_ptr);
      nib = o[4*w +: 4];
      exp_y = eval_nib(nib);
      bus.req  = r;
      bus.opnd = o;
      bus.res_ready = 1'($urandom);
      tick();
      check("gnt_onehot", 32'(bus.gnt), 32'(1) << w);
      check("busy_eval", 32'(bus.busy), 1);
      check("valid_eval", 32'(bus.res_valid), 0);
      // Later operand and request changes must not affect this result.
      bus.opnd = 16'($urandom);
      bus.req  = 4'($urandom);
      tick();
      check("gnt_clear", 32'(bus.gnt), 0);
      check("valid_hold", 32'(bus.res_valid), 1);
      check("res_y", 32'(bus.res_y), 32'(exp_y));
      check("res_id", 32'(bus.res_id), 32'(w));
      for (int h = 0; h < hold; h++) begin
         bus.res_ready = 1'b0;
         bus.req       = 4'($urandom);
         tick();
         check("hold_valid", 32'(bus.res_valid), 1);
         check("hold_y", 32'(bus.res_y), 32'(exp_y));
         check("hold_id", 32'(bus.res_id), 32'(w));
         check("hold_nognt", 32'(bus.gnt), 0);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      m_ptr = (w + 1) % NREQ;
`ifdef ANDOR_OPCNT_EN
      if (m_cnt < (1 << CNTW) - 1) m_cnt++;
`endif
      check("valid_drop", 32'(bus.res_valid), 0);
      check("busy_idle", 32'(bus.busy), 0);
      check("op_count", 32'(bus.op_count), 32'(m_cnt));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_ptr = 0;
      m_cnt = 0;
      rst   = 1'b1;
      bus.req       = '0;
      bus.opnd      = '0;
      bus.res_ready = 1'b0;
      #1;
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_valid", 32'(bus.res_valid), 0);
      check("rst_y", 32'(bus.res_y), 0);
      check("rst_id", 32'(bus.res_id), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_cnt", 32'(bus.op_count), 0);
      tick();
      #2 rst = 1'b0;
      tick();
      check("idle_nogrant", 32'(bus.gnt), 0);

      // Single request from requester 0, a=0 b=1 c=1 d=1.
      do_op(4'b0001, 16'h0007, 0);

      // Reset while in EVAL discards the operation and rewinds the pointer.
      bus.req       = 4'b0010;
      bus.res_ready = 1'b1;
      tick();
      check("pre_rst_gnt", 32'(bus.gnt), 32'b0010);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_gnt", 32'(bus.gnt), 0);
      check("mid_rst_valid", 32'(bus.res_valid), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_cnt", 32'(bus.op_count), 0);
      bus.req = '0;
      m_ptr = 0;
      m_cnt = 0;
      #1 rst = 1'b0;
      tick();
      check("post_rst_busy", 32'(bus.busy), 0);

      // All requesting: rotation 0,1,2,3,0, every result 0.
      for (int i = 0; i < 5; i++) begin
         check("fair_order", 32'(winner(4'b1111, m_ptr)), 32'(i % NREQ));
         do_op(4'b1111, 16'h2222, 0);
      end

      // Requester 2 held 5 cycles by back-pressure, then requester 0 served.
      do_op(4'b0100, 16'h0C00, 5);
      do_op(4'b0001, 16'h0000, 0);

      // Randomized transactions with idle gaps.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            bus.req = '0;
            tick();
            check("idle_gnt", 32'(bus.gnt), 0);
            check("idle_busy", 32'(bus.busy), 0);
         end
         do_op(4'($urandom_range(1, 15)), 16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
